conv_window_scan_ctrl: RTL and testbench

- Sequences the zero-padded image ROM for a KxK convolution engine.
- For every output pixel, in raster order, issues the K*K neighbourhood read addresses (pxl_row, pxl_col) to the ROM.
- The ROM has a registered read with 1-cycle latency. The block tracks that latency and presents each returned byte to the downstream MAC as a valid/ready tap stream with tap index and output coordinates.
- Sits between the top-level start/done control and the image ROM / MAC datapath.

---
 rtl/conv_window_scan_ctrl_if.sv | 31 +++
 rtl/conv_window_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_conv_window_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_scan_ctrl_if.sv
// Handshake and bus bundle between the window scan controller, the image ROM and the MAC.
// Signal prefixes are from the controller's point of view.
interface conv_window_scan_ctrl_if;
    logic       i_start;
    logic [7:0] o_pxl_row;
    logic [8:0] o_pxl_col;
    logic [7:0] i_mem_data;
    logic       o_tap_valid;
    logic       i_tap_ready;
    logic [7:0] o_tap_data;
    logic [3:0] o_tap_idx;
    logic       o_win_last;
    logic [7:0] o_out_row;
    logic [8:0] o_out_col;
    logic       o_busy;
    logic       o_done;

    // Controller side
    modport master (
        input  i_start, i_mem_data, i_tap_ready,
        output o_pxl_row, o_pxl_col, o_tap_valid, o_tap_data, o_tap_idx, o_win_last,
               o_out_row, o_out_col, o_busy, o_done
    );

    // Environment side (start control, ROM, MAC)
    modport slave (
        output i_start, i_mem_data, i_tap_ready,
        input  o_pxl_row, o_pxl_col, o_tap_valid, o_tap_data, o_tap_idx, o_win_last,
               o_out_row, o_out_col, o_busy, o_done
    );
endinterface

// File: rtl/conv_window_scan_ctrl.sv
// KxK window scan controller: walks every output pixel in raster order, issues the K*K
// neighbourhood addresses to a 1-cycle-latency ROM and presents the returned bytes as a
// valid/ready tap stream tagged with tap index and output coordinates.
module conv_window_scan_ctrl #(
    parameter int unsigned R_IMG = 202,
    parameter int unsigned C_IMG = 302,
    parameter int unsigned K     = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    conv_window_scan_ctrl_if.master io_bus
);

    localparam logic [7:0] OrowMax = 8'(R_IMG - K);
    localparam logic [8:0] OcolMax = 9'(C_IMG - K);
    localparam logic [3:0] DMax    = 4'(K - 1);
    localparam logic [3:0] KW      = 4'(K);
    localparam logic [3:0] IdxMax  = 4'(K * K - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e     r_state;
    state_e     w_state_next;

    // Issue counters
    logic [7:0] r_orow;
    logic [8:0] r_ocol;
    logic [3:0] r_dr;
    logic [3:0] r_dc;

    // Presented tap
    logic       r_tap_valid;
    logic [7:0] r_tap_row;
    logic [8:0] r_tap_col;
    logic [3:0] r_tap_idx;
    logic       r_win_last;
    logic [7:0] r_out_row;
    logic [8:0] r_out_col;

    logic       w_adv;
    logic       w_stall;
    logic       w_accept;
    logic       w_issue;
    logic       w_clear;
    logic       w_last_issue;
    logic [8:0] w_issue_row;
    logic [8:0] w_issue_col;
    logic [3:0] w_issue_idx;

    assign w_adv        = !r_tap_valid || io_bus.i_tap_ready;
    assign w_stall      = r_tap_valid && !io_bus.i_tap_ready;
    assign w_accept     = r_tap_valid && io_bus.i_tap_ready;
    assign w_issue_row  = {1'b0, r_orow} + {5'b0, r_dr};
    assign w_issue_col  = r_ocol + {5'b0, r_dc};
    assign w_issue_idx  = r_dr * KW + r_dc;
    assign w_last_issue = (r_orow == OrowMax) && (r_ocol == OcolMax) &&
                          (r_dr == DMax) && (r_dc == DMax);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus issue/clear strobes for the counters
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_clear = 1'b1;
                if (io_bus.i_start) begin
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (w_adv) begin
                    w_issue = 1'b1;
                    if (w_last_issue) begin
                        w_state_next = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_accept) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Nested issue counters: dc fastest, then dr, ocol, orow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_orow <= '0;
            r_ocol <= '0;
            r_dr   <= '0;
            r_dc   <= '0;
        end else if (w_clear) begin
            r_orow <= '0;
            r_ocol <= '0;
            r_dr   <= '0;
            r_dc   <= '0;
        end else if (w_issue) begin
            if (r_dc == DMax) begin
                r_dc <= '0;
                if (r_dr == DMax) begin
                    r_dr <= '0;
                    if (r_ocol == OcolMax) begin
                        r_ocol <= '0;
                        r_orow <= (r_orow == OrowMax) ? '0 : r_orow + 8'd1;
                    end else begin
                        r_ocol <= r_ocol + 9'd1;
                    end
                end else begin
                    r_dr <= r_dr + 4'd1;
                end
            end else begin
                r_dc <= r_dc + 4'd1;
            end
        end
    end

    // Presented-tap registers; data arrives from the ROM in the same cycle tap_valid rises
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tap_valid <= 1'b0;
            r_tap_row   <= '0;
            r_tap_col   <= '0;
            r_tap_idx   <= '0;
            r_win_last  <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else if (w_issue) begin
            r_tap_valid <= 1'b1;
            r_tap_row   <= w_issue_row[7:0];
            r_tap_col   <= w_issue_col;
            r_tap_idx   <= w_issue_idx;
            r_win_last  <= (w_issue_idx == IdxMax);
            r_out_row   <= r_orow;
            r_out_col   <= r_ocol;
        end else if (w_accept) begin
            r_tap_valid <= 1'b0;
        end
    end

    // ROM has no enable: on a stall re-address the presented tap so the read data holds
    assign io_bus.o_pxl_row   = w_stall ? r_tap_row : w_issue_row[7:0];
    assign io_bus.o_pxl_col   = w_stall ? r_tap_col : w_issue_col;
    assign io_bus.o_tap_valid = r_tap_valid;
    assign io_bus.o_tap_data  = io_bus.i_mem_data;
    assign io_bus.o_tap_idx   = r_tap_idx;
    assign io_bus.o_win_last  = r_win_last;
    assign io_bus.o_out_row   = r_out_row;
    assign io_bus.o_out_col   = r_out_col;
    assign io_bus.o_busy      = (r_state == StScan) || (r_state == StDrain);
    assign io_bus.o_done      = (r_state == StDone);

endmodule

// File: tb/tb_conv_window_scan_ctrl.sv
// Directed bench for conv_window_scan_ctrl on a 5x6 padded image with a 3x3 window.
module tb_conv_window_scan_ctrl;

    localparam int R    = 5;
    localparam int C    = 6;
    localparam int K    = 3;
    localparam int NWR  = R - K + 1;
    localparam int NWC  = C - K + 1;
    localparam int NTAP = NWR * NWC * K * K;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic       last;
        logic [7:0] orow;
        logic [8:0] ocol;
        logic [7:0] ar;
        logic [8:0] ac;
    } tap_t;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic [7:0] orow;
        logic [8:0] ocol;
        logic [7:0] prow;
        logic [8:0] pcol;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0]  rom_q;
    logic [16:0] addr_q;

    int n_tests = 0;
    int n_fail  = 0;

    tap_t  gold [NTAP];
    tap_t  got  [NTAP];
    snap_t snap [16];
    int    ntap, ndone, t_first, t_last_acc, t_done, nsnap;
    bit    tmo;

    conv_window_scan_ctrl_if bus ();

    conv_window_scan_ctrl #(
        .R_IMG (R),
        .C_IMG (C),
        .K     (K)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input int r, input int c);
        return 8'(r * 37 + c * 11 + 3);
    endfunction

    // Registered-read ROM model; addr_q remembers which address produced rom_q
    always @(posedge clk) begin
        rom_q  <= rom_val(int'(bus.o_pxl_row), int'(bus.o_pxl_col));
        addr_q <= {bus.o_pxl_row, bus.o_pxl_col};
    end
    assign bus.i_mem_data = rom_q;

    task automatic build_gold();
        for (int n = 0; n < NTAP; n++) begin
            int orow, ocol, k, dr, dc;
            orow = n / (NWC * K * K);
            ocol = (n % (NWC * K * K)) / (K * K);
            k    = n % (K * K);
            dr   = k / K;
            dc   = k % K;
            gold[n].data = rom_val(orow + dr, ocol + dc);
            gold[n].idx  = 4'(k);
            gold[n].last = (k == K * K - 1);
            gold[n].orow = 8'(orow);
            gold[n].ocol = 9'(ocol);
            gold[n].ar   = 8'(orow + dr);
            gold[n].ac   = 9'(ocol + dc);
        end
    endtask

    // Drives one frame and records accepted taps; rmode 0 = ready high, 1 = random.
    task automatic run_frame(input int rmode, input int start_tap, input int stall_tap,
                             input int stall_len);
        bit pulsed = 0;
        ntap = 0; ndone = 0; t_first = -1; t_last_acc = -1; t_done = -1; nsnap = 0; tmo = 1;
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_tap_ready = 1'b1;
        for (int t = 1; t < 3000; t++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (start_tap >= 0 && !pulsed && ntap == start_tap) begin
                bus.i_start = 1'b1;
                pulsed = 1;
            end
            bus.i_tap_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_tap >= 0 && ntap == stall_tap && bus.o_tap_valid && nsnap < stall_len)
                bus.i_tap_ready = 1'b0;
            #1;
            if (!bus.i_tap_ready && stall_tap >= 0 && ntap == stall_tap && bus.o_tap_valid
                && nsnap < stall_len) begin
                snap[nsnap] = {bus.o_tap_data, bus.o_tap_idx, bus.o_out_row, bus.o_out_col,
                               bus.o_pxl_row, bus.o_pxl_col};
                nsnap++;
            end
            if (bus.o_tap_valid && t_first < 0) t_first = t;
            if (bus.o_done) begin
                ndone++;
                t_done = t;
            end
            if (bus.o_tap_valid && bus.i_tap_ready) begin
                if (ntap < NTAP)
                    got[ntap] = {bus.o_tap_data, bus.o_tap_idx, bus.o_win_last, bus.o_out_row,
                                 bus.o_out_col, addr_q};
                ntap++;
                t_last_acc = t;
            end
            if (t_done >= 0 && t >= t_done + 3) begin
                tmo = 0;
                break;
            end
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [48:0] outs;
        bit seen;
        bus.i_start     = 1'b0;
        bus.i_tap_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        outs = {bus.o_tap_valid, bus.o_busy, bus.o_done, bus.o_tap_idx, bus.o_win_last,
                bus.o_out_row, bus.o_out_col, bus.o_pxl_row, bus.o_pxl_col};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_tap_valid !== 1'b0 || bus.o_busy !== 1'b0) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL idle_no_start: got activity=1 want 0");
        end
    endtask

    task automatic test_full_frame();
        int bad = 0;
        run_frame(0, -1, -1, 0);
        n_tests++;
        if (tmo !== 0) begin n_fail++; $display("FAIL full_timeout: got 1 want 0"); end
        n_tests++;
        if (ntap !== NTAP) begin n_fail++; $display("FAIL full_count: got %0d want %0d", ntap, NTAP); end
        n_tests++;
        if (t_first !== 2) begin n_fail++; $display("FAIL first_latency: got %0d want 2", t_first); end
        n_tests++;
        if ({got[0].idx, got[0].ar, got[0].ac, got[0].data} !== {4'd0, 8'd0, 9'd0, rom_val(0, 0)}) begin
            n_fail++;
            $display("FAIL first_tap: got %h want idx0 addr(0,0)", got[0]);
        end
        n_tests++;
        if ({got[8].idx, got[8].last, got[8].ar, got[8].ac} !== {4'd8, 1'b1, 8'd2, 9'd2}) begin
            n_fail++;
            $display("FAIL ninth_tap: got %h want idx8 last1 addr(2,2)", got[8]);
        end
        n_tests++;
        if ({got[NTAP-1].orow, got[NTAP-1].ocol, got[NTAP-1].ar, got[NTAP-1].ac}
            !== {8'd2, 9'd3, 8'd4, 9'd5}) begin
            n_fail++;
            $display("FAIL last_tap: got %h want out(2,3) addr(4,5)", got[NTAP-1]);
        end
        for (int n = 0; n < NTAP; n++) begin
            n_tests++;
            if (got[n] !== gold[n]) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL full_tap%0d: got %h want %h", n, got[n], gold[n]);
            end
        end
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", ndone); end
        n_tests++;
        if (t_done !== t_last_acc + 1) begin
            n_fail++;
            $display("FAIL done_timing: got %0d want %0d", t_done, t_last_acc + 1);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        run_frame(1, -1, -1, 0);
        n_tests++;
        if (tmo !== 0 || ntap !== NTAP) begin
            n_fail++;
            $display("FAIL bp_count: got %0d tmo=%0d want %0d", ntap, tmo, NTAP);
        end
        for (int n = 0; n < NTAP; n++)
            if (got[n] !== gold[n]) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_taps: got %0d bad want 0", bad); end
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", ndone); end
    endtask

    task automatic test_long_stall();
        int bad = 0;
        snap_t want;
        run_frame(0, -1, 58, 10);
        want = {rom_val(2, 3), 4'd4, 8'd1, 9'd2, 8'd2, 9'd3};
        n_tests++;
        if (nsnap !== 10) begin n_fail++; $display("FAIL stall_len: got %0d want 10", nsnap); end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (snap[i] !== want) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h want %h", i, snap[i], want);
            end
        end
        for (int n = 0; n < NTAP; n++)
            if (got[n] !== gold[n]) bad++;
        n_tests++;
        if (tmo !== 0 || ntap !== NTAP || bad !== 0) begin
            n_fail++;
            $display("FAIL stall_resume: got n=%0d bad=%0d want n=%0d bad=0", ntap, bad, NTAP);
        end
    endtask

    task automatic test_reset_mid_frame();
        int  cnt = 0;
        bit  dseen = 0;
        bit  hit = 0;
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_tap_ready = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            #1;
            if (bus.o_tap_valid && bus.i_tap_ready) cnt++;
            if (cnt == 50) begin hit = 1; break; end
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL rst_mid_reach: got %0d taps want 50", cnt); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.o_tap_valid, bus.o_busy, bus.o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b want 000",
                     {bus.o_tap_valid, bus.o_busy, bus.o_done});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0 || bus.o_tap_valid !== 1'b0) dseen = 1;
        end
        n_tests++;
        if (dseen) begin n_fail++; $display("FAIL rst_mid_no_done: got activity want none"); end
        run_frame(0, -1, -1, 0);
        n_tests++;
        if ({got[0].ar, got[0].ac, got[0].idx} !== {8'd0, 9'd0, 4'd0} || ntap !== NTAP) begin
            n_fail++;
            $display("FAIL rst_restart: got addr(%0d,%0d) n=%0d want (0,0) n=%0d",
                     got[0].ar, got[0].ac, ntap, NTAP);
        end
    endtask

    task automatic test_start_while_busy();
        int bad = 0;
        run_frame(0, 30, -1, 0);
        for (int n = 0; n < NTAP; n++)
            if (got[n] !== gold[n]) bad++;
        n_tests++;
        if (tmo !== 0 || ntap !== NTAP || bad !== 0) begin
            n_fail++;
            $display("FAIL busy_start_taps: got n=%0d bad=%0d want n=%0d bad=0", ntap, bad, NTAP);
        end
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL busy_start_done: got %0d want 1", ndone); end
    endtask

    initial begin
        build_gold();
        test_reset();
        test_full_frame();
        test_backpressure();
        test_long_stall();
        test_reset_mid_frame();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
